// File: rtl/dpram_pkg.sv
// Shared types and the per-byte merge used by dual_port_ram_bytewr for both the
// array update and read sampling, so stored and returned words always agree.
package dpram_pkg;

    typedef enum logic {COL_A_WINS, COL_B_WINS} col_policy_e;

    localparam int LATENCY_MAX = 4;
    localparam int MERGE_MAX_W = 512;

    // Lane masks are one bit per byte lane; data is zero-extended to MERGE_MAX_W.
    function automatic logic [MERGE_MAX_W-1:0] merge_bytes(
        input logic [MERGE_MAX_W-1:0] old,
        input logic [MERGE_MAX_W-1:0] da,
        input logic [MERGE_MAX_W-1:0] wa,
        input logic [MERGE_MAX_W-1:0] db,
        input logic [MERGE_MAX_W-1:0] wb,
        input col_policy_e            policy,
        input int                     byte_w
    );
        logic [MERGE_MAX_W-1:0]         res;
        logic [$clog2(MERGE_MAX_W)-1:0] lane;
        for (int i = 0; i < MERGE_MAX_W; i++) begin
            lane = ($clog2(MERGE_MAX_W))'(i / byte_w);
            if (wa[lane] && wb[lane])
                res[i] = (policy == COL_A_WINS) ? da[i] : db[i];
            else if (wa[lane])
                res[i] = da[i];
            else if (wb[lane])
                res[i] = db[i];
            else
                res[i] = old[i];
        end
        return res;
    endfunction

endpackage

// File: rtl/dpram_rd_pipe.sv
// Read-return pipeline for one RAM port: LATENCY-deep valid/data shift register,
// cleared asynchronously so in-flight reads never surface after a reset.
module dpram_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vld,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_vld,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [LATENCY-1:0]    vld_p;
    logic [DATA_WIDTH-1:0] data_p [LATENCY];

    // Each stage only loads on a valid, so the last stage holds between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            for (int i = 0; i < LATENCY; i++) data_p[i] <= '0;
        end else begin
            vld_p[0] <= in_vld;
            if (in_vld) data_p[0] <= in_data;
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
                if (vld_p[i-1]) data_p[i] <= data_p[i-1];
            end
        end
    end

    assign out_vld  = vld_p[LATENCY-1];
    assign out_data = data_p[LATENCY-1];

endmodule

// File: rtl/dual_port_ram_bytewr.sv
// True dual-port RAM with byte write enables, write-first reads, programmable read
// latency and a deterministic per-byte winner on same-address writes.
module dual_port_ram_bytewr
    import dpram_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          BYTE_WIDTH = 8,
    parameter int          SIZE       = 1024,
    parameter int          LATENCY    = 1,
    parameter col_policy_e COLLISION  = COL_A_WINS,
    localparam int         NB         = DATA_WIDTH / BYTE_WIDTH,
    localparam int         AW         = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [NB-1:0]         wea,
    input  logic [AW-1:0]         addra,
    input  logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] douta,
    output logic                  rvalida,
    input  logic                  enb,
    input  logic [NB-1:0]         web,
    input  logic [AW-1:0]         addrb,
    input  logic [DATA_WIDTH-1:0] dinb,
    output logic [DATA_WIDTH-1:0] doutb,
    output logic                  rvalidb,
    output logic                  collision
);

    if (LATENCY < 1 || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("dual_port_ram_bytewr: LATENCY must be in 1..%0d", LATENCY_MAX);
    end
    if (DATA_WIDTH % BYTE_WIDTH != 0 || DATA_WIDTH > MERGE_MAX_W) begin : g_bad_width
        $error("dual_port_ram_bytewr: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if ((1 << AW) != SIZE) begin : g_bad_size
        $error("dual_port_ram_bytewr: SIZE must be a power of 2");
    end

    logic [DATA_WIDTH-1:0] mem [SIZE];

    logic                  same_addr;
    logic [NB-1:0]         wa_own, wb_own, wa_cross, wb_cross;
    logic [DATA_WIDTH-1:0] samp_a, samp_b;

    function automatic logic [DATA_WIDTH-1:0] merge_word(
        input logic [DATA_WIDTH-1:0] old,
        input logic [DATA_WIDTH-1:0] da,
        input logic [NB-1:0]         wa,
        input logic [DATA_WIDTH-1:0] db,
        input logic [NB-1:0]         wb
    );
        return DATA_WIDTH'(merge_bytes(MERGE_MAX_W'(old), MERGE_MAX_W'(da), MERGE_MAX_W'(wa),
                                       MERGE_MAX_W'(db), MERGE_MAX_W'(wb), COLLISION, BYTE_WIDTH));
    endfunction

    // The other port's lanes only count when it targets the same word this cycle.
    assign same_addr = (addra == addrb);
    assign wa_own    = ena ? wea : '0;
    assign wb_own    = enb ? web : '0;
    assign wa_cross  = same_addr ? wa_own : '0;
    assign wb_cross  = same_addr ? wb_own : '0;

    assign samp_a = merge_word(mem[addra], dina, wa_own, dinb, wb_cross);
    assign samp_b = merge_word(mem[addrb], dina, wa_cross, dinb, wb_own);

    // On a shared address samp_a == samp_b, so the double write is consistent.
    always_ff @(posedge clk) begin
        if (rst_n && (|wa_own)) mem[addra] <= samp_a;
        if (rst_n && (|wb_own)) mem[addrb] <= samp_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) collision <= 1'b0;
        else        collision <= ena && enb && same_addr && (|(wea & web));
    end

    dpram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .LATENCY(LATENCY)) u_pipe_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (ena),
        .in_data  (samp_a),
        .out_vld  (rvalida),
        .out_data (douta)
    );

    dpram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .LATENCY(LATENCY)) u_pipe_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (enb),
        .in_data  (samp_b),
        .out_vld  (rvalidb),
        .out_data (doutb)
    );

endmodule

// File: tb/tb_dual_port_ram_bytewr.sv
// Bench for dual_port_ram_bytewr: four instances (latency 1..4, instance 2 uses
// COL_B_WINS) share one stimulus stream; a byte-lane model feeds per-port queues.
module tb_dual_port_ram_bytewr;
    import dpram_pkg::*;

    localparam int NI = 4;

    logic        clk, rst_n, ena, enb;
    logic [3:0]  wea, web;
    logic [9:0]  addra, addrb;
    logic [31:0] dina, dinb;
    logic [31:0] dout [NI][2];
    logic        rv   [NI][2];
    logic        col  [NI];

    typedef struct { int due; logic [31:0] data; } rd_t;
    typedef struct { int due; logic exp; } col_t;

    rd_t         rdq [NI][2][$];
    col_t        colq[$];
    logic [31:0] mdl [2][1024];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic        rst_req;

    dual_port_ram_bytewr #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .SIZE(1024), .LATENCY(1), .COLLISION(COL_A_WINS)) u0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(dout[0][0]),
        .rvalida(rv[0][0]), .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(dout[0][1]),
        .rvalidb(rv[0][1]), .collision(col[0]));
    dual_port_ram_bytewr #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .SIZE(1024), .LATENCY(2), .COLLISION(COL_A_WINS)) u1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(dout[1][0]),
        .rvalida(rv[1][0]), .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(dout[1][1]),
        .rvalidb(rv[1][1]), .collision(col[1]));
    dual_port_ram_bytewr #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .SIZE(1024), .LATENCY(3), .COLLISION(COL_B_WINS)) u2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(dout[2][0]),
        .rvalida(rv[2][0]), .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(dout[2][1]),
        .rvalidb(rv[2][1]), .collision(col[2]));
    dual_port_ram_bytewr #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .SIZE(1024), .LATENCY(4), .COLLISION(COL_A_WINS)) u3 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(dout[3][0]),
        .rvalida(rv[3][0]), .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(dout[3][1]),
        .rvalidb(rv[3][1]), .collision(col[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [31:0] mdl_merge(input logic [31:0] old, input logic [31:0] da,
                                              input logic [3:0] wa, input logic [31:0] db,
                                              input logic [3:0] wb, input bit bwin);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (wa[i] && (!wb[i] || !bwin)) r[8*i +: 8] = da[8*i +: 8];
            else if (wb[i])                 r[8*i +: 8] = db[8*i +: 8];
        end
        return r;
    endfunction

    // One clock cycle of stimulus; expected read/collision results are queued here.
    task automatic drive(input logic ea, input logic [3:0] wa, input logic [9:0] aa, input logic [31:0] da,
                         input logic eb, input logic [3:0] wb, input logic [9:0] ab, input logic [31:0] db);
        logic [31:0] sa [2];
        logic [31:0] sb [2];
        logic [3:0]  wae, wbe;
        rd_t         e;
        col_t        c;
        int          pol;
        @(negedge clk);
        rst_n = rst_req;
        ena = ea; wea = wa; addra = aa; dina = da;
        enb = eb; web = wb; addrb = ab; dinb = db;
        if (rst_req) begin
            wae = ea ? wa : 4'h0;
            wbe = eb ? wb : 4'h0;
            for (int p = 0; p < 2; p++) begin
                sa[p] = mdl_merge(mdl[p][aa], da, wae, db, (aa == ab) ? wbe : 4'h0, p == 1);
                sb[p] = mdl_merge(mdl[p][ab], da, (aa == ab) ? wae : 4'h0, db, wbe, p == 1);
                if (wae != 4'h0) mdl[p][aa] = sa[p];
                if (wbe != 4'h0) mdl[p][ab] = sb[p];
            end
            for (int k = 0; k < NI; k++) begin
                pol = (k == 2) ? 1 : 0;
                e.due = cyc + k + 1;
                if (ea) begin e.data = sa[pol]; rdq[k][0].push_back(e); end
                if (eb) begin e.data = sb[pol]; rdq[k][1].push_back(e); end
            end
            c.due = cyc + 1;
            c.exp = ea && eb && (aa == ab) && ((wa & wb) != 4'h0);
            colq.push_back(c);
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 4'h0, 10'h0, 32'h0, 1'b0, 4'h0, 10'h0, 32'h0);
    endtask

    // Monitor: every cycle, read results and the collision pulse against the queues.
    initial forever begin
        rd_t  e;
        col_t c;
        logic exp_col;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (rdq[k][p].size() > 0 && rdq[k][p][0].due == cyc) begin
                    e = rdq[k][p].pop_front();
                    total++;
                    if (rv[k][p] !== 1'b1 || dout[k][p] !== e.data) begin
                        bad++;
                        $display("FAIL rd_u%0d_p%0d cyc=%0d got rvalid=%b dout=%h want rvalid=1 dout=%h",
                                 k, p, cyc, rv[k][p], dout[k][p], e.data);
                    end
                end else if (rv[k][p] !== 1'b0) begin
                    total++;
                    bad++;
                    $display("FAIL stray_rvalid_u%0d_p%0d cyc=%0d got rvalid=%b want 0", k, p, cyc, rv[k][p]);
                end
            end
        end
        exp_col = 1'b0;
        if (colq.size() > 0 && colq[0].due == cyc) begin
            c = colq.pop_front();
            exp_col = c.exp;
        end
        for (int k = 0; k < NI; k++) begin
            total++;
            if (col[k] !== exp_col) begin
                bad++;
                $display("FAIL collision_u%0d cyc=%0d got %b want %b", k, cyc, col[k], exp_col);
            end
        end
    end

    task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst_req = 1'b0;
        repeat (3) drive(1'b1, 4'hF, 10'h000, 32'hA0A0A0A0, 1'b1, 4'hF, 10'h001, 32'hB1B1B1B1);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            for (int p = 0; p < 2; p++) begin
                total++;
                if (dout[k][p] !== 32'h0 || rv[k][p] !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_out_u%0d_p%0d got dout=%h rvalid=%b want 0/0", k, p, dout[k][p], rv[k][p]);
                end
            end
            total++;
            if (col[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset_col_u%0d got %b want 0", k, col[k]);
            end
        end
        rst_req = 1'b1;
        drive(1'b1, 4'hF, 10'h000, 32'hA0A0A0A0, 1'b1, 4'hF, 10'h001, 32'hB1B1B1B1);
        idle(5);
        check_word("reset_first_a_u3", dout[3][0], 32'hA0A0A0A0);
        check_word("reset_first_b_u0", dout[0][1], 32'hB1B1B1B1);
    endtask

    task automatic test_byte_mask();
        drive(1'b1, 4'hF, 10'h010, 32'hAABBCCDD, 1'b0, 4'h0, 10'h0, 32'h0);
        drive(1'b1, 4'h5, 10'h010, 32'h11223344, 1'b0, 4'h0, 10'h0, 32'h0);
        drive(1'b1, 4'h0, 10'h010, 32'h0, 1'b0, 4'h0, 10'h0, 32'h0);
        idle(5);
        check_word("byte_mask_u0", dout[0][0], 32'hAA22CC44);
        check_word("byte_mask_u2", dout[2][0], 32'hAA22CC44);
    endtask

    task automatic test_collision();
        drive(1'b1, 4'hF, 10'h020, 32'h0, 1'b0, 4'h0, 10'h0, 32'h0);
        drive(1'b1, 4'h3, 10'h020, 32'h11111111, 1'b1, 4'h6, 10'h020, 32'h22222222);
        drive(1'b1, 4'h0, 10'h020, 32'h0, 1'b0, 4'h0, 10'h0, 32'h0);
        idle(5);
        check_word("collision_a_wins", dout[0][0], 32'h00221111);
        check_word("collision_b_wins", dout[2][0], 32'h00222211);
        check_word("collision_b_wins_portb", dout[2][1], 32'h00222211);
    endtask

    task automatic test_cross_forward();
        drive(1'b1, 4'hF, 10'h030, 32'h0, 1'b0, 4'h0, 10'h0, 32'h0);
        drive(1'b1, 4'h0, 10'h030, 32'h0, 1'b1, 4'hF, 10'h030, 32'hDEADBEEF);
        idle(5);
        check_word("forward_lat1", dout[0][0], 32'hDEADBEEF);
        check_word("forward_lat2", dout[1][0], 32'hDEADBEEF);
        check_word("forward_lat4", dout[3][0], 32'hDEADBEEF);
    endtask

    task automatic test_inflight();
        drive(1'b1, 4'hF, 10'h040, 32'h5, 1'b0, 4'h0, 10'h0, 32'h0);
        drive(1'b1, 4'h0, 10'h040, 32'h0, 1'b0, 4'h0, 10'h0, 32'h0);
        drive(1'b0, 4'h0, 10'h000, 32'h0, 1'b1, 4'hF, 10'h040, 32'h9);
        drive(1'b1, 4'h0, 10'h040, 32'h0, 1'b0, 4'h0, 10'h0, 32'h0);
        idle(5);
        check_word("inflight_reread_lat3", dout[2][0], 32'h9);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++)
            drive(1'b1, 4'hF, 10'h060 + 10'(i), $urandom, 1'b1, 4'(i), 10'h070 + 10'(i), $urandom);
        for (int i = 0; i < 8; i++)
            drive(1'b1, 4'h0, 10'h060 + 10'(i), 32'h0, 1'b1, 4'h0, 10'h077 - 10'(i), 32'h0);
        for (int i = 0; i < 4; i++)
            drive(1'b1, 4'(i * 5), 10'h068, $urandom, 1'b1, 4'(15 - i * 3), 10'h068, $urandom);
        idle(5);
    endtask

    task automatic test_reset_midflight();
        drive(1'b1, 4'hF, 10'h050, 32'h12345678, 1'b0, 4'h0, 10'h0, 32'h0);
        drive(1'b1, 4'h0, 10'h050, 32'h0, 1'b1, 4'h0, 10'h050, 32'h0);
        #1 rst_n = 1'b0;
        rst_req = 1'b0;
        for (int k = 0; k < NI; k++) begin
            rdq[k][0].delete();
            rdq[k][1].delete();
        end
        colq.delete();
        drive(1'b1, 4'h0, 10'h050, 32'h0, 1'b1, 4'hF, 10'h050, 32'hFFFFFFFF);
        rst_req = 1'b1;
        idle(6);
        drive(1'b1, 4'h0, 10'h050, 32'h0, 1'b0, 4'h0, 10'h0, 32'h0);
        idle(5);
        check_word("midflight_retained", dout[3][0], 32'h12345678);
    endtask

    initial begin
        rst_n = 1'b1; rst_req = 1'b0;
        ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
        addra = '0; addrb = '0; dina = '0; dinb = '0;
        for (int p = 0; p < 2; p++)
            for (int a = 0; a < 1024; a++) mdl[p][a] = 32'h0;
        #1 rst_n = 1'b0;
        test_reset();
        test_byte_mask();
        test_collision();
        test_cross_forward();
        test_inflight();
        test_back_to_back();
        test_reset_midflight();
        idle(6);
        for (int k = 0; k < NI; k++) begin
            for (int p = 0; p < 2; p++) begin
                total++;
                if (rdq[k][p].size() != 0) begin
                    bad++;
                    $display("FAIL leftover_u%0d_p%0d got %0d pending want 0", k, p, rdq[k][p].size());
                end
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
